// File: rtl/ledr_pwm_driver_if.sv
// Avalon-MM slave register bus for the LEDR PWM driver.
interface ledr_pwm_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/ledr_pwm_driver.sv
// LEDR PWM dimmer with optional per-LED blinking.
// Blink logic (prescaler, BLINK_DIV, BLINK_MASK) is built only when LEDR_BLINK_EN is defined.
module ledr_pwm_driver #(
  parameter int NUM_LEDS    = 10,
  parameter int BLINK_DIV_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] ledr,
  ledr_pwm_driver_if.slave    bus
);

  logic                   wr;
  logic [NUM_LEDS-1:0]    led_q;
  logic [7:0]             pwm_cnt;
  logic [7:0]             duty;
  logic [7:0]             duty_active;
  logic                   pwm_wrap;
  logic                   pwm_on;
  logic [BLINK_DIV_W-1:0] blink_div;
  logic [NUM_LEDS-1:0]    blink_mask;
  logic                   blink_phase;
  logic [NUM_LEDS-1:0]    blink_gate;
  logic                   unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign pwm_wrap     = (pwm_cnt == 8'd254);
  assign pwm_on       = (pwm_cnt < duty_active);
  assign blink_gate   = ~blink_mask | {NUM_LEDS{blink_phase}};
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q       <= '0;
      pwm_cnt     <= '0;
      duty        <= 8'hFF;
      duty_active <= 8'hFF;
      ledr        <= '0;
    end else begin
      led_q   <= led_in;
      pwm_cnt <= pwm_wrap ? 8'd0 : pwm_cnt + 8'd1;
      // Shadow only updates at the period boundary so a period never changes width midway.
      if (pwm_wrap)
        duty_active <= duty;
      if (wr && bus.address == 2'd0)
        duty <= bus.writedata[7:0];
      ledr <= led_q & {NUM_LEDS{pwm_on}} & blink_gate;
    end
  end

`ifdef LEDR_BLINK_EN
  logic [BLINK_DIV_W-1:0] presc;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_div   <= '0;
      blink_mask  <= '0;
      presc       <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (wr && bus.address == 2'd2)
        blink_mask <= bus.writedata[NUM_LEDS-1:0];
      // A BLINK_DIV write restarts the blink and takes priority over a terminal count.
      if (wr && bus.address == 2'd1) begin
        blink_div   <= bus.writedata[BLINK_DIV_W-1:0];
        presc       <= '0;
        blink_phase <= 1'b1;
      end else if (blink_div == '0) begin
        presc       <= '0;
        blink_phase <= 1'b1;
      end else if (presc == blink_div - BLINK_DIV_W'(1)) begin
        presc       <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        presc <= presc + BLINK_DIV_W'(1);
      end
    end
  end
`else
  assign blink_div   = '0;
  assign blink_mask  = '0;
  assign blink_phase = 1'b1;
`endif

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(duty);
      2'd1:    bus.readdata = 32'(blink_div);
      2'd2:    bus.readdata = 32'(blink_mask);
      default: bus.readdata = {16'd0, pwm_cnt, 7'd0, blink_phase};
    endcase
  end

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// Randomized self-checking bench for ledr_pwm_driver against a cycle-count based model.
module tb_ledr_pwm_driver;
  localparam int NL = 10;
  localparam int BW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] led_in;
  logic [NL-1:0] ledr;

  ledr_pwm_driver_if bus();

  ledr_pwm_driver #(.NUM_LEDS(NL), .BLINK_DIV_W(BW)) dut (
    .clk    (clk),
    .reset  (reset),
    .led_in (led_in),
    .ledr   (ledr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

`ifdef LEDR_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Model: t = edges since reset, tb = edges since reset or last BLINK_DIV write.
  int          t, tb;
  bit [7:0]    m_duty, m_dact;
  int unsigned m_div;
  bit [NL-1:0] m_mask, m_ledq, m_ledr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit m_phase();
    if (m_div == 0) return 1'b1;
    return 1'b1 ^ bit'((tb / m_div) & 1);
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_duty);
      2'd1:    return 32'(m_div);
      2'd2:    return 32'(m_mask);
      default: return {16'd0, 8'(t % 255), 7'd0, m_phase()};
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      t = 0; tb = 0;
      m_duty = 8'hFF; m_dact = 8'hFF; m_div = 0; m_mask = '0;
      m_ledq = '0; m_ledr = '0;
    end else begin
      m_ledr = m_ledq & (((t % 255) < m_dact) ? {NL{1'b1}} : {NL{1'b0}})
                      & (~m_mask | (m_phase() ? {NL{1'b1}} : {NL{1'b0}}));
      m_ledq = led_in;
      t++; tb++;
      if (t % 255 == 0) m_dact = m_duty;
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          2'd0: m_duty = bus.writedata[7:0];
          2'd1: if (BLINK) begin m_div = bus.writedata & 32'h00FF_FFFF; tb = 0; end
          2'd2: if (BLINK) m_mask = bus.writedata[NL-1:0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (checking) begin
      chk("ledr", 32'(ledr), 32'(m_ledr));
      chk($sformatf("rdata@%0d", bus.address), bus.readdata, m_rd(bus.address));
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic readback_all();
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      chk($sformatf("rb@%0d", a), bus.readdata, m_rd(2'(a)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_wrap();
    for (int i = 0; i < 300 && (t % 255) != 0; i++) tick();
    chk("wrap_reached", 32'(t % 255), 32'd0);
  endtask

  int hi;

  initial begin
    reset = 1'b1; led_in = '0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    tick(); tick();
    checking = 1'b1;
    do_reset();
    chk("rst_ledr", 32'(ledr), 32'd0);
    bus.address = 2'd0; #1; chk("rst_duty", bus.readdata, 32'hFF);
    bus.address = 2'd1; #1; chk("rst_div", bus.readdata, 32'h0);
    bus.address = 2'd3; #1; chk("rst_status", bus.readdata, 32'h1);

    // All on at full duty: visible on the second edge.
    led_in = 10'h3FF;
    tick(); chk("lat1", 32'(ledr), 32'd0);
    tick(); chk("lat2", 32'(ledr), 32'h3FF);
    for (int i = 0; i < 20; i++) tick();
    chk("steady", 32'(ledr), 32'h3FF);

    // Duty 64 over one full period, then duty 0.
    led_in = 10'h001;
    bus_write(2'd0, 32'hABCD_0040);
    wait_wrap();
    hi = 0;
    for (int i = 0; i < 255; i++) begin tick(); hi += int'(ledr[0]); end
    chk("duty64_count", 32'(hi), 32'd64);
    bus_write(2'd0, 32'd0);
    wait_wrap(); tick();
    hi = 0;
    for (int i = 0; i < 255; i++) begin tick(); hi += int'(ledr[0]); end
    chk("duty0_count", 32'(hi), 32'd0);

    // Duty change mid-period at pwm_cnt=100.
    for (int i = 0; i < 300 && (t % 255) != 99; i++) tick();
    bus_write(2'd0, 32'd200);
    hi = 0;
    for (int i = 0; i < 255 - 100; i++) begin tick(); hi += int'(ledr[0]); end
    chk("old_duty_kept", 32'(hi), 32'd0);

    // Blink setup; address 1 reads 0 when blinking is not built.
    bus_write(2'd0, 32'hFF);
    led_in = 10'h003;
    bus_write(2'd1, 32'h5);
    readback_all();
    bus_write(2'd1, 32'h4);
    bus_write(2'd2, 32'h002);
    for (int i = 0; i < 600; i++) tick();
    readback_all();

    // Reset pulse mid-blink with LEDs lit.
    do_reset();
    chk("midrst_ledr", 32'(ledr), 32'd0);
    bus.address = 2'd0; #1; chk("midrst_duty", bus.readdata, 32'hFF);
    bus.address = 2'd1; #1; chk("midrst_div", bus.readdata, 32'h0);

    // Random traffic.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 15) == 0) led_in = NL'($urandom);
      bus.address = 2'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: bus_write(2'd0, $urandom);
          1: bus_write(2'd1, {8'($urandom), 24'($urandom_range(0, 6))});
          2: bus_write(2'd2, $urandom);
          default: bus_write(2'd3, $urandom);
        endcase
      end else begin
        bus.chipselect = 1'($urandom);
        tick();
        bus.chipselect = 1'b0;
      end
    end
    readback_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ledr_pwm_driver.md
LEDR_PWM_DRIVER -- requirements
Module: ledr_pwm_driver

Interface
REQ-001 The block SHALL have the parameter NUM_LEDS, default 10, giving the width of the LED input and output buses.
REQ-002 The block SHALL have the parameter BLINK_DIV_W, default 24, giving the width of the blink prescaler register.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have the port led_in, input, NUM_LEDS bits: the LED on/off pattern from the upstream LEDR PIO.
REQ-006 The block SHALL have the port address, input, 2 bits: the Avalon-MM register select.
REQ-007 The block SHALL have the port chipselect, input, 1 bit: the Avalon-MM slave select.
REQ-008 The block SHALL have the port write_n, input, 1 bit: the Avalon-MM write strobe, active-low.
REQ-009 The block SHALL have the port writedata, input, 32 bits: the Avalon-MM write data.
REQ-010 The block SHALL have the port readdata, output, 32 bits: the Avalon-MM read data.
REQ-011 The block SHALL have the port ledr, output, NUM_LEDS bits: the drive to the physical LEDs.

Function
REQ-012 Register map SHALL be: 0 = DUTY[7:0]; 1 = BLINK_DIV[BLINK_DIV_W-1:0]; 2 = BLINK_MASK[NUM_LEDS-1:0]; 3 = STATUS (read-only: bit0 blink_phase, bits15:8 pwm_cnt).
REQ-013 A write SHALL occur on a clock edge with chipselect=1 and write_n=0; upper writedata bits beyond the field width SHALL be ignored; writes to address 3 SHALL be ignored.
REQ-014 readdata SHALL be combinational from address with zero wait states, unused bits 0; DUTY reads return the written value, not the active shadow.
REQ-015 led_in SHALL be registered once into led_q each cycle.
REQ-016 pwm_cnt (8-bit) SHALL count 0..254 and wrap to 0, giving a period of 255 cycles.
REQ-017 duty_active SHALL load from DUTY only on the cycle pwm_cnt wraps 254->0, so there are no mid-period glitches.
REQ-018 pwm_on SHALL be (pwm_cnt < duty_active): DUTY=0 gives always off, and DUTY=255 gives always on.
REQ-019 The blink prescaler SHALL count 0..BLINK_DIV-1; on reaching BLINK_DIV-1 it SHALL reset to 0 and toggle blink_phase.
REQ-020 BLINK_DIV=0 SHALL hold the prescaler at 0 and blink_phase at 1, so blinking is disabled.
REQ-021 Any write to BLINK_DIV SHALL clear the prescaler and set blink_phase=1 on the same edge.
REQ-022 ledr[i] SHALL be registered as led_q[i] & pwm_on & (~BLINK_MASK[i] | blink_phase).
REQ-023 Latency from led_in to ledr SHALL be 2 cycles; latency from a BLINK_MASK write to ledr SHALL be 1 cycle.
REQ-024 When a register write and a prescaler terminal count occur simultaneously, the write SHALL win.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL set ledr=0, led_q=0, pwm_cnt=0, DUTY=duty_active=8'hFF, BLINK_DIV=0, BLINK_MASK=0, prescaler=0, and blink_phase=1.
REQ-026 Reset asserted mid-period or mid-blink SHALL abort the period or blink immediately, with no residual state.
REQ-027 readdata SHALL reflect the reset register values in the cycle after reset deasserts.

Configuration
REQ-028 With macro LEDR_BLINK_EN defined, the prescaler, BLINK_DIV, BLINK_MASK and blink_phase SHALL be implemented as specified above.
REQ-029 Without LEDR_BLINK_EN, that blink logic SHALL be absent: addresses 1 and 2 read 0, writes to them are ignored, STATUS bit0 reads 1, and REQ-022 reduces to led_q[i] & pwm_on.

Verification
REQ-030 Scenario: reset, then led_in=10'h3FF with defaults -> ledr=10'h3FF from the 2nd cycle after led_in is applied, held steady.
REQ-031 Scenario: DUTY=64, led_in=10'h001 -> after the next wrap, ledr[0] is high for exactly 64 of every 255 cycles; DUTY=0 gives a constant 0.
REQ-032 Scenario: a DUTY write at pwm_cnt=100 -> the current period keeps the old duty, and the new duty applies from pwm_cnt=0.
REQ-033 Scenario: BLINK_DIV=4, BLINK_MASK=10'h002, led_in=10'h003 -> ledr[1] toggles every 4 cycles while ledr[0] stays steadily high.
REQ-034 Scenario: reset pulsed for 1 cycle mid-blink with ledr nonzero -> the next cycle ledr=0, and readdata at address 0 is 32'hFF, at address 1 is 0.
REQ-035 Scenario: build without LEDR_BLINK_EN, write 5 to address 1 -> reading address 1 returns 0, and ledr is unaffected.
